hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage miniRV core. It keeps a three-slot scoreboard of the in-flight destination registers in EX, MEM and WB, and checks the two ID-stage source registers against it. From that it drives stall, flush and operand-forwarding selects to the PC, IF/ID and ID/EX registers. It sits beside the ID stage and consumes the same decode fields that feed the ID/EX register.

## Interface
Parameters:
- none (encodings come from the shared package)

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset; **synchronous, active-high**
- id_rs1_i  in  5  ID-stage source register 1 index
- id_rs2_i  in  5  ID-stage source register 2 index
- id_re1_i  in  1  ID instruction reads rs1
- id_re2_i  in  1  ID instruction reads rs2
- id_wR_i  in  5  ID-stage destination register
- id_rf_we_i  in  1  ID instruction writes the register file
- id_rf_wsel_i  in  2  ID write-back source select; WSEL_DRAM marks a load
- ex_br_taken_i  in  1  EX stage redirects the PC (taken branch or jump)
- pc_stall_o  out  1  hold the PC
- if_id_stall_o  out  1  hold IF/ID
- if_id_flush_o  out  1  load NOP into IF/ID on the next edge
- id_ex_flush_o  out  1  load a bubble (all control = 0) into ID/EX on the next edge
- fwd1_sel_o  out  2  rD1 source: FWD_RF, FWD_EX, FWD_MEM or FWD_WB
- fwd2_sel_o  out  2  rD2 source, same encoding

## Operation
Scoreboard:
- Three slots: EX, MEM, WB. Each slot holds {valid, wR[4:0], is_load}.
- A slot is valid only if rf_we = 1 and wR ≠ 0.

Shift on every clock edge when not in reset:
- WB takes MEM.
- MEM takes EX.
- EX takes the ID info, or an invalid slot if id_ex_flush_o = 1 that cycle.

Match definition:
- Slot S matches rsN when S.valid, S.wR == rsN, id_reN = 1 and rsN ≠ 0.
- Register x0 never creates a hazard or a forward.

Stall, with FORWARD_EN defined:
- load_use = the EX slot is a load and matches rs1 or rs2.

Stall, without FORWARD_EN:
- load_use = any of EX, MEM or WB matches rs1 or rs2.

Priority (combinational, evaluated every cycle):
1. ex_br_taken_i = 1: if_id_flush_o = 1 and id_ex_flush_o = 1; pc_stall_o = 0 and if_id_stall_o = 0. The redirect overrides any stall because the ID instruction is killed.
2. Else if load_use = 1: pc_stall_o = 1, if_id_stall_o = 1, id_ex_flush_o = 1, if_id_flush_o = 0.
3. Else: all four stall/flush outputs are 0.

Forwarding, per operand, when FORWARD_EN is defined:
- The first matching slot in order EX, MEM, WB sets the select to FWD_EX, FWD_MEM or FWD_WB. No match selects FWD_RF.
- Outputs are forced to FWD_RF while load_use or ex_br_taken_i is 1.
- A MEM-slot load is a valid forward source; loaded data is available at the MEM output.

## Timing
- Reset state: all scoreboard slots invalid. While rst_i = 1, every output is 0 and both selects are FWD_RF. The first edge with rst_i = 0 performs a normal shift.
- Latency: all outputs are combinational from the inputs and scoreboard, so they are valid in the same cycle the ID instruction is present.
- Load-use stall lasts exactly 1 cycle with forwarding. The bubble then moves the load to MEM and the consumer forwards FWD_MEM.
- Without forwarding, a dependent instruction stalls for up to 3 cycles, until the producer has left WB. The register file is not write-through.
- Simultaneous ex_br_taken_i and load_use: the flush wins. No stall cycle is spent.
- Back-to-back taken branches: each one flushes independently.
- Reset asserted mid-stall: the scoreboard clears at that edge and the stall drops in the same cycle.

## Configuration
- Macro: HAZARD_FORWARD_EN.
- Defined: the forwarding network is active and only load-use hazards stall.
- Undefined: forwarding logic is compiled out, fwd1_sel_o and fwd2_sel_o are tied to FWD_RF, and every RAW hazard against EX, MEM or WB stalls.

## Structure
- Shared package pipe_pkg holds:
  - FWD_RF=2'd0, FWD_EX=2'd1, FWD_MEM=2'd2, FWD_WB=2'd3
  - WSEL_DRAM=2'b01
  - the scoreboard slot struct {valid, wR, is_load}
- Sub-module hazard_match: one slot compared against one source index, returning the match bit. Instantiate it six times (3 slots × 2 operands).

## Test plan
- Reset, then `addi x5` followed by `add x6,x5,x5`: fwd1/fwd2 = FWD_EX, no stall. Without the macro, stall is held for 3 cycles.
- `lw x7`, then `add x8,x7,x0`: 1-cycle stall with id_ex_flush=1, then fwd1 = FWD_MEM, fwd2 = FWD_RF.
- Producers writing x9 in EX, MEM and WB together, consumer reads x9: select = FWD_EX (priority check).
- Instruction `add x0,...` followed by a reader of x0: no stall, select = FWD_RF.
- Load-use hazard coinciding with ex_br_taken_i=1: both flushes = 1, stalls = 0, and no bubble is counted on the next cycle.
- rst_i raised during a no-forward 3-cycle stall: outputs are 0 in the same cycle, and the scoreboard is empty after the edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared miniRV pipeline encodings: forwarding selects, write-back select and scoreboard slot.
// Used by hazard_unit, whose forwarding network is enabled with HAZARD_FORWARD_EN.
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   localparam logic [1:0] WSEL_DRAM = 2'b01;

   typedef struct packed {
      logic       valid;
      logic [4:0] wR;
      logic       is_load;
   } sb_slot_t;

   // x0 writes and non-writing instructions never occupy a slot
   function automatic sb_slot_t make_slot(logic rf_we, logic [4:0] wr, logic [1:0] wsel);
      sb_slot_t s;
      s.valid   = rf_we && (wr != 5'd0);
      s.wR      = wr;
      s.is_load = (wsel == WSEL_DRAM);
      return s;
   endfunction

   // Match vector is ordered {WB, MEM, EX}; the youngest producer wins
   function automatic logic [1:0] fwd_pick(logic [2:0] m);
      if (m[0]) return FWD_EX;
      if (m[1]) return FWD_MEM;
      if (m[2]) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// One scoreboard slot compared against one ID-stage source register.
module hazard_match
   import pipe_pkg::*;
(
   input  sb_slot_t   slot_i,
   input  logic [4:0] rs_i,
   input  logic       re_i,
   output logic       match_o
);

   assign match_o = slot_i.valid && (slot_i.wR == rs_i) && re_i && (rs_i != 5'd0);

endmodule

// File: rtl/hazard_unit.sv
// miniRV hazard controller: EX/MEM/WB destination scoreboard, stall/flush and forwarding selects.
// Define HAZARD_FORWARD_EN to enable forwarding; otherwise every RAW hazard stalls.
module hazard_unit
   import pipe_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_re1_i,
   input  logic       id_re2_i,
   input  logic [4:0] id_wR_i,
   input  logic       id_rf_we_i,
   input  logic [1:0] id_rf_wsel_i,
   input  logic       ex_br_taken_i,
   output logic       pc_stall_o,
   output logic       if_id_stall_o,
   output logic       if_id_flush_o,
   output logic       id_ex_flush_o,
   output logic [1:0] fwd1_sel_o,
   output logic [1:0] fwd2_sel_o
);

   sb_slot_t ex_q, mem_q, wb_q, ex_d;
   sb_slot_t slots [3];
   logic [2:0] m1, m2;
   logic load_use;
   logic unused_is_load;

   assign slots[0] = ex_q;
   assign slots[1] = mem_q;
   assign slots[2] = wb_q;

   for (genvar i = 0; i < 3; i++) begin : g_match
      hazard_match u_match1 (
         .slot_i  (slots[i]),
         .rs_i    (id_rs1_i),
         .re_i    (id_re1_i),
         .match_o (m1[i])
      );
      hazard_match u_match2 (
         .slot_i  (slots[i]),
         .rs_i    (id_rs2_i),
         .re_i    (id_re2_i),
         .match_o (m2[i])
      );
   end

`ifdef HAZARD_FORWARD_EN
   assign load_use = ex_q.is_load && (m1[0] || m2[0]);
`else
   assign load_use = (|m1) || (|m2);
`endif

   assign unused_is_load = ^{ex_q.is_load, mem_q.is_load, wb_q.is_load};

   always_comb begin
      pc_stall_o    = 1'b0;
      if_id_stall_o = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      fwd1_sel_o    = FWD_RF;
      fwd2_sel_o    = FWD_RF;
      if (!rst_i) begin
         // A redirect kills the ID instruction, so any pending stall is moot
         if (ex_br_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end
`ifdef HAZARD_FORWARD_EN
         if (!ex_br_taken_i && !load_use) begin
            fwd1_sel_o = fwd_pick(m1);
            fwd2_sel_o = fwd_pick(m2);
         end
`endif
      end
   end

   always_comb begin
      ex_d = make_slot(id_rf_we_i, id_wR_i, id_rf_wsel_i);
      if (id_ex_flush_o) ex_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit; honours HAZARD_FORWARD_EN the same way as the design.
module tb_hazard_unit;
   import pipe_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, wr;
   logic       re1, re2, we, br;
   logic [1:0] wsel;
   logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
   logic [1:0] fwd1, fwd2;
   logic [7:0] obs, exp_v;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB
   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       ld;
   } ent_t;
   ent_t pipe_m [3];

   always #5 clk = ~clk;

   hazard_unit dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .id_rs1_i      (rs1),
      .id_rs2_i      (rs2),
      .id_re1_i      (re1),
      .id_re2_i      (re2),
      .id_wR_i       (wr),
      .id_rf_we_i    (we),
      .id_rf_wsel_i  (wsel),
      .ex_br_taken_i (br),
      .pc_stall_o    (pc_stall),
      .if_id_stall_o (if_id_stall),
      .if_id_flush_o (if_id_flush),
      .id_ex_flush_o (id_ex_flush),
      .fwd1_sel_o    (fwd1),
      .fwd2_sel_o    (fwd2)
   );

   assign obs = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, fwd1, fwd2};

   function automatic int first_hit(logic [4:0] rs, logic re);
      if (!re || rs == 5'd0) return -1;
      for (int k = 0; k < 3; k++)
         if (pipe_m[k].v && pipe_m[k].rd == rs) return k;
      return -1;
   endfunction

   // Expected {pc_stall, if_id_stall, if_id_flush, id_ex_flush, fwd1, fwd2}
   function automatic logic [7:0] model_out();
      int h1, h2;
      bit lu;
      logic [1:0] f1, f2;
      if (rst) return 8'h00;
      h1 = first_hit(rs1, re1);
      h2 = first_hit(rs2, re2);
`ifdef HAZARD_FORWARD_EN
      lu = pipe_m[0].ld && (h1 == 0 || h2 == 0);
      f1 = (h1 < 0) ? 2'd0 : 2'(h1 + 1);
      f2 = (h2 < 0) ? 2'd0 : 2'(h2 + 1);
`else
      lu = (h1 >= 0) || (h2 >= 0);
      f1 = 2'd0;
      f2 = 2'd0;
`endif
      if (br) return 8'b0011_0000;
      if (lu) return 8'b1101_0000;
      return {4'b0000, f1, f2};
   endfunction

   task automatic tick();
      logic [7:0] e;
      e = model_out();
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 3; k++) pipe_m[k] = '{v: 0, rd: 0, ld: 0};
      end else begin
         pipe_m[2] = pipe_m[1];
         pipe_m[1] = pipe_m[0];
         pipe_m[0].v  = !e[4] && we && (wr != 5'd0);
         pipe_m[0].rd = wr;
         pipe_m[0].ld = (wsel == WSEL_DRAM);
      end
      #1;
   endtask

   task automatic drive(input logic [4:0] a, input logic ea, input logic [4:0] b,
                        input logic eb, input logic [4:0] d, input logic w,
                        input logic [1:0] s, input logic bt);
      rs1 = a; re1 = ea; rs2 = b; re2 = eb; wr = d; we = w; wsel = s; br = bt;
   endtask

   task automatic drain();
      drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(5, 1, 5, 1, 5, 1, WSEL_DRAM, 1);
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected %b", obs, 8'h00);
      end
      tick();
      tick();
      rst = 1'b0;
      drive(5, 1, 5, 1, 6, 1, 2'b00, 0);
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_empty_sb: got %b expected %b", obs, 8'h00);
      end
      tick();
      drain();
   endtask

   task automatic test_alu_dep();
      drive(0, 1, 0, 0, 5, 1, 2'b00, 0);
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL alu_producer: got %b expected %b", obs, 8'h00);
      end
      tick();
      drive(5, 1, 5, 1, 6, 1, 2'b00, 0);
`ifdef HAZARD_FORWARD_EN
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h05) begin
         n_fail++;
         $display("FAIL alu_fwd_ex: got %b expected %b", obs, 8'h05);
      end
      tick();
`else
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++;
         if (obs !== 8'hD0) begin
            n_fail++;
            $display("FAIL alu_stall cycle %0d: got %b expected %b", c, obs, 8'hD0);
         end
         tick();
      end
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL alu_stall_release: got %b expected %b", obs, 8'h00);
      end
      tick();
`endif
      drain();
   endtask

   task automatic test_load_use();
      drive(0, 1, 0, 0, 7, 1, WSEL_DRAM, 0);
      tick();
      drive(7, 1, 0, 1, 8, 1, 2'b00, 0);
`ifdef HAZARD_FORWARD_EN
      @(negedge clk);
      n_tests++;
      if (obs !== 8'hD0) begin
         n_fail++;
         $display("FAIL load_use_stall: got %b expected %b", obs, 8'hD0);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h08) begin
         n_fail++;
         $display("FAIL load_use_fwd_mem: got %b expected %b", obs, 8'h08);
      end
      tick();
`else
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_tests++;
         if (obs !== ((c < 3) ? 8'hD0 : 8'h00)) begin
            n_fail++;
            $display("FAIL load_use_nofwd cycle %0d: got %b expected %b", c, obs,
                     (c < 3) ? 8'hD0 : 8'h00);
         end
         tick();
      end
`endif
      drain();
   endtask

   task automatic test_priority();
      repeat (3) begin
         drive(0, 0, 0, 0, 9, 1, 2'b00, 0);
         tick();
      end
      drive(9, 1, 9, 1, 10, 1, 2'b00, 0);
      @(negedge clk);
      n_tests++;
`ifdef HAZARD_FORWARD_EN
      if (obs !== 8'h05) begin
         n_fail++;
         $display("FAIL fwd_priority: got %b expected %b", obs, 8'h05);
      end
`else
      if (obs !== 8'hD0) begin
         n_fail++;
         $display("FAIL nofwd_priority: got %b expected %b", obs, 8'hD0);
      end
`endif
      tick();
      drain();
   endtask

   task automatic test_x0();
      drive(0, 1, 0, 1, 0, 1, WSEL_DRAM, 0);
      tick();
      drive(0, 1, 0, 1, 11, 1, 2'b00, 0);
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL x0_reader: got %b expected %b", obs, 8'h00);
      end
      tick();
      drain();
   endtask

   task automatic test_branch_load_use();
      drive(0, 1, 0, 0, 7, 1, WSEL_DRAM, 0);
      tick();
      drive(7, 1, 0, 0, 8, 1, 2'b00, 1);
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h30) begin
         n_fail++;
         $display("FAIL branch_over_load_use: got %b expected %b", obs, 8'h30);
      end
      tick();
      // Load has moved on to MEM: no extra bubble was spent
      drive(7, 1, 0, 0, 10, 1, 2'b00, 0);
      @(negedge clk);
      n_tests++;
`ifdef HAZARD_FORWARD_EN
      if (obs !== 8'h08) begin
         n_fail++;
         $display("FAIL branch_after_fwd: got %b expected %b", obs, 8'h08);
      end
`else
      if (obs !== 8'hD0) begin
         n_fail++;
         $display("FAIL branch_after_nofwd: got %b expected %b", obs, 8'hD0);
      end
`endif
      tick();
      drive(0, 0, 0, 0, 0, 0, 2'b00, 1);
      tick();
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h30) begin
         n_fail++;
         $display("FAIL back_to_back_branch: got %b expected %b", obs, 8'h30);
      end
      tick();
      drain();
   endtask

   task automatic test_reset_mid_stall();
      drive(0, 1, 0, 0, 5, 1, WSEL_DRAM, 0);
      tick();
      drive(5, 1, 5, 1, 6, 1, 2'b00, 0);
      @(negedge clk);
      n_tests++;
      if (obs !== 8'hD0) begin
         n_fail++;
         $display("FAIL mid_stall_pre: got %b expected %b", obs, 8'hD0);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_stall_reset_comb: got %b expected %b", obs, 8'h00);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_stall_sb_cleared: got %b expected %b", obs, 8'h00);
      end
      tick();
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         drive(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
               ($urandom_range(0, 7) == 0));
         exp_v = model_out();
         @(negedge clk);
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL random cycle %0d: got %b expected %b", c, obs, exp_v);
         end
         tick();
      end
      rst = 1'b0;
      drain();
   endtask

   initial begin
      for (int k = 0; k < 3; k++) pipe_m[k] = '{v: 0, rd: 0, ld: 0};
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
      test_reset();
      test_alu_dep();
      test_load_use();
      test_priority();
      test_x0();
      test_branch_load_use();
      test_reset_mid_stall();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
